// File: rtl/inert_spi_pkg.sv
// Shared definitions for the inertial-sensor SPI responder: register map
// addresses, interrupt-enable bit position, frame length and FSM states.
package inert_spi_pkg;

  localparam logic [6:0] INT_CFG_ADDR   = 7'h0D;
  localparam logic [6:0] WHO_AM_I_ADDR  = 7'h0F;
  localparam logic [6:0] ACCEL_CFG_ADDR = 7'h10;
  localparam logic [6:0] GYRO_CFG_ADDR  = 7'h11;
  localparam logic [6:0] PTCH_L_ADDR    = 7'h22;
  localparam logic [6:0] PTCH_H_ADDR    = 7'h23;
  localparam logic [6:0] AZ_L_ADDR      = 7'h2C;
  localparam logic [6:0] AZ_H_ADDR      = 7'h2D;

  localparam int unsigned INT_EN_BIT = 1;
  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_t;

endpackage

// File: rtl/inert_spi_resp_sync.sv
// spi_in_sync: N-flop synchronizer for one asynchronous SPI pin, with
// single-clk rise/fall pulses on the synchronized value. Edge pulses are
// suppressed until the chain has been refilled with real samples after
// reset, so a pin already sitting at its non-reset level does not look
// like an edge.
module spi_in_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;
  logic [STAGES:0]   fill;
  logic              armed;

  // Synchronizer chain, delayed copy for edge detect, and post-reset fill tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
      fill  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
      fill  <= {fill[STAGES-1:0], 1'b1};
    end
  end

  assign q     = chain[STAGES-1];
  assign armed = fill[STAGES];
  assign rise  = armed &  q & ~q_d;
  assign fall  = armed & ~q &  q_d;

endmodule

// File: rtl/inert_spi_resp.sv
// inert_spi_resp: SPI (mode 0, 16-bit frame) responder modelling the inertial
// sensor's register map inside the plant model. Optional macro
// INERT_MISO_TRI_EN tri-states MISO while the synchronized SS_n is high.
module inert_spi_resp
  import inert_spi_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        samp_vld,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] az,
  output logic [7:0]  gyro_cfg,
  output logic [7:0]  accel_cfg
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d(SS_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_q, mosi_rise, mosi_fall};

  spi_state_t  state_q, state_d;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_shft;
  logic [15:0] tx_shft;
  logic [7:0]  rd_data;
  logic [7:0]  rd_mux;
  logic [6:0]  cmd_addr;
  logic [7:0]  int_cfg;
  logic [15:0] ptch_reg, az_reg;
  logic        pend;
  logic [15:0] pend_ptch, pend_az;
  logic        commit, wr_commit, azh_clear, apply;

  // At the 8th rise the address is the 6 bits already shifted in plus the live MOSI bit.
  assign cmd_addr = {rx_shft[5:0], mosi_q};

  // Read-data decode for the address being completed.
  always_comb begin
    rd_mux = 8'h00;
    case (cmd_addr)
      INT_CFG_ADDR:   rd_mux = int_cfg;
      WHO_AM_I_ADDR:  rd_mux = WHO_AM_I_VAL;
      ACCEL_CFG_ADDR: rd_mux = accel_cfg;
      GYRO_CFG_ADDR:  rd_mux = gyro_cfg;
      PTCH_L_ADDR:    rd_mux = ptch_reg[7:0];
      PTCH_H_ADDR:    rd_mux = ptch_reg[15:8];
      AZ_L_ADDR:      rd_mux = az_reg[7:0];
      AZ_H_ADDR:      rd_mux = az_reg[15:8];
      default:        rd_mux = 8'h00;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame sequencing: SS_n rise always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (ss_fall) state_d = CMD;
        CMD:  if (sclk_rise && bit_cnt == 5'(FRAME_BITS/2 - 1)) state_d = DATA;
        DATA: if (sclk_rise && bit_cnt == 5'(FRAME_BITS - 1)) state_d = DONE;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift datapath: receive on SCLK rise, transmit update on SCLK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_shft <= '0;
      tx_shft <= '0;
      rd_data <= '0;
    end else if (ss_fall) begin
      bit_cnt <= '0;
      tx_shft <= '0;
    end else if (state_q == CMD || state_q == DATA) begin
      if (sclk_rise) begin
        bit_cnt <= bit_cnt + 5'd1;
        rx_shft <= {rx_shft[14:0], mosi_q};
        if (state_q == CMD && bit_cnt == 5'(FRAME_BITS/2 - 1))
          rd_data <= rd_mux;
        // Last bit already presented; MISO drops to 0 for the remainder.
        if (state_q == DATA && bit_cnt == 5'(FRAME_BITS - 1))
          tx_shft <= '0;
      end else if (sclk_fall) begin
        if (bit_cnt == 5'(FRAME_BITS/2)) tx_shft <= {rd_data, 8'h00};
        else                             tx_shft <= {tx_shft[14:0], 1'b0};
      end
    end
  end

  assign commit    = ss_rise && (state_q == DONE);
  assign wr_commit = commit && !rx_shft[15];
  assign azh_clear = commit && rx_shft[15] && (rx_shft[14:8] == AZ_H_ADDR);
  // Samples go straight in while idle; otherwise they wait for the frame to end.
  assign apply     = (samp_vld && (state_q == IDLE || ss_rise)) || (ss_rise && pend);

  // Register map, sample holding and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_cfg   <= '0;
      accel_cfg <= '0;
      gyro_cfg  <= '0;
      ptch_reg  <= '0;
      az_reg    <= '0;
      pend      <= 1'b0;
      pend_ptch <= '0;
      pend_az   <= '0;
      INT       <= 1'b0;
    end else begin
      if (wr_commit) begin
        case (rx_shft[14:8])
          INT_CFG_ADDR:   int_cfg   <= rx_shft[7:0];
          ACCEL_CFG_ADDR: accel_cfg <= rx_shft[7:0];
          GYRO_CFG_ADDR:  gyro_cfg  <= rx_shft[7:0];
          default: ;
        endcase
      end
      if (apply) begin
        ptch_reg <= samp_vld ? ptch_rt : pend_ptch;
        az_reg   <= samp_vld ? az      : pend_az;
      end
      if (ss_rise) begin
        pend <= 1'b0;
      end else if (samp_vld && state_q != IDLE) begin
        pend      <= 1'b1;
        pend_ptch <= ptch_rt;
        pend_az   <= az;
      end
      // A new sample's set takes priority over an AZ_H read clear.
      if (apply && int_cfg[INT_EN_BIT]) INT <= 1'b1;
      else if (azh_clear)               INT <= 1'b0;
    end
  end

`ifdef INERT_MISO_TRI_EN
  assign MISO = ss_q ? 1'bz : tx_shft[15];
`else
  assign MISO = ss_q ? 1'b0 : tx_shft[15];
`endif

endmodule
